gaussian_column_feeder: RTL and testbench
=========================================

# gaussian_column_feeder

Front-end feeder for the 5x5 Gaussian filter. It accepts a raster-order image one pixel per cycle into an internal frame buffer. It then streams 5-pixel vertical columns, band by band, on the filter's five pixel inputs, holding `enable` high for one unbroken run. When the last column has been sent it drops `enable` and reports `done`. This gives the filter its terminal over transition.

## Interface
- `BIT_LENGTH`, default 5: pixel width in bits.
- `IMG_WIDTH`, default 16: image columns W; legal range is 1 or more.
- `IMG_HEIGHT`, default 16: image rows H; legal range is 5 or more.
- `clk`  input  1  clock.
- `reset`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  `pixel_in` carries a raster pixel this cycle.
- `pixel_in`  input  BIT_LENGTH  raster pixel, row-major order: row 0 col 0 first.
- `in_ready`  output  1  feeder accepts a pixel this cycle; high only in LOAD.
- `pixel_out1`..`pixel_out5`  output  BIT_LENGTH each  column rows r..r+4 (top to bottom) at column c; connect to the filter's `pixel_in1`..`pixel_in5`.
- `enable`  output  1  column outputs valid; drives the filter's `enable`.
- `done`  output  1  whole image streamed; sticky until reset.

## Operation
- Frame buffer has W*H entries of BIT_LENGTH bits, indexed row*W+col. It needs no reset and its contents after reset are don't-care.
- A pixel is accepted when `in_valid` && `in_ready`.
- Counters:
  - write index: 0..W*H-1.
  - band r: 0..H-5.
  - column c: 0..W-1.
  - Width of each counter is $clog2 of its range, minimum 1 bit.
- FSM states are LOAD, STREAM and DONE.
  - **LOAD** (reset state):
    - `in_ready`=1.
    - Each accepted pixel is written at the write index, and the write index increments.
    - Accepting pixel W*H-1 moves the FSM to STREAM.
    - Cycles with `in_valid`=0 are stalls: nothing is written.
  - **STREAM**:
    - `in_ready`=0.
    - Every cycle, without stalls, the feeder emits column (r,c) = mem[(r+k)*W+c] for k=0..4.
    - c increments each cycle. At c=W-1, c wraps to 0 and r increments.
    - After emitting (H-5, W-1) the FSM moves to DONE.
    - Total STREAM length is (H-4)*W cycles.
  - **DONE**:
    - `in_ready`=0.
    - The FSM stays in DONE until reset.
    - `in_valid` is ignored.
- `in_valid` outside LOAD is ignored: no write occurs and no counter moves.
- Band seams:
  - `enable` does not drop between bands, as the filter requires.
  - Filter outputs whose window spans two bands are garbage. Downstream discards the first 4 filter outputs of each band.
- Reset mid-operation, in any state:
  - FSM returns to LOAD.
  - All counters clear.
  - The next accepted pixel is treated as row 0 col 0.

## Timing
- All outputs are registered.
- Reset values:
  - `in_ready`=1.
  - `enable`=0.
  - `done`=0.
  - `pixel_out1`..`pixel_out5`=0.
- `in_ready` is combinational from state, so it is 1 during LOAD, including the cycle right after reset deasserts.
- Latency from load to stream:
  - The last pixel is accepted at edge k.
  - Column (0,0) and `enable`=1 are visible after edge k+1.
  - Column (r,c) appears at edge k+1+r*W+c.
- End of stream:
  - `enable` is high for exactly (H-4)*W consecutive cycles.
  - On the edge after the last column, `enable`=0, `done`=1 and `pixel_out`=0.
- Outputs are 0 whenever `enable`=0.
- The memory read path may be a registered address plus a registered output stage, provided the latency above holds.

## Test plan
- **Reset values**: assert reset mid-cycle -> `in_ready`=1, `enable`=0, `done`=0 and all `pixel_out`=0 immediately; `in_ready`=1 remains once reset deasserts.
- **Nominal stream, W=8, H=6**: load pixel=(row*8+col) mod 32 with continuous `in_valid`.
  - `enable` rises 1 cycle after the 48th accept and stays high 16 cycles.
  - First column = 0,8,16,24,0.
  - Column (1,0) = 8,16,24,0,8.
  - Last column (1,7) = 15,23,31,7,15.
  - `done` rises the cycle `enable` falls.
- **Load stalls**: same image with `in_valid` toggled randomly -> stream identical to the nominal case; `enable` starts 1 cycle after the 48th accept.
- **Ignored input**: hold `in_valid`=1 with pixel 31 through STREAM and DONE -> column values unchanged; `done` stays 1 and `enable` stays 0 indefinitely.
- **Reset mid-stream**: assert reset at stream cycle 5, then reload a constant-7 image -> fresh full stream with all columns 7,7,7,7,7, 16 cycles long.
- **Minimum height, W=16, H=5 (defaults except H)**: single band -> `enable` high exactly 16 cycles with no band wrap; end-to-end with the Gaussian filter, a constant-31 image gives filter outputs matching the filter's own constant-input response after the first 4.

Source files
------------

// File: rtl/gaussian_column_feeder.sv
// Frame-buffered feeder for a 5x5 Gaussian filter: loads a raster image, then
// streams 5-tall vertical columns band by band under one unbroken enable run.
module gaussian_column_feeder #(
  parameter int BIT_LENGTH = 5,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  output logic                  in_ready,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic [BIT_LENGTH-1:0] pixel_out3,
  output logic [BIT_LENGTH-1:0] pixel_out4,
  output logic [BIT_LENGTH-1:0] pixel_out5,
  output logic                  enable,
  output logic                  done
);

  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int BANDS = IMG_HEIGHT - 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (BANDS > 1) ? $clog2(BANDS) : 1;

  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_base;
  logic [ROW_W-1:0]        band;
  logic [COL_W-1:0]        col;
  logic [BIT_LENGTH-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]        rd_addr [5];
  logic                    accept;
  logic                    last_col;
  logic                    last_band;

  assign in_ready  = (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign last_col  = (col == COL_W'(IMG_WIDTH - 1));
  assign last_band = (band == ROW_W'(BANDS - 1));

  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx] <= pixel_in;
  end

  // Raster order makes (r,c) -> next column a plain +1, so rd_base is
  // r*W+c and each tap is a whole image row further down.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      rd_addr[k] = rd_base + IDX_W'(k * IMG_WIDTH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      wr_idx     <= '0;
      rd_base    <= '0;
      band       <= '0;
      col        <= '0;
      enable     <= 1'b0;
      done       <= 1'b0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      pixel_out3 <= '0;
      pixel_out4 <= '0;
      pixel_out5 <= '0;
    end else begin
      case (state)
        LOAD: begin
          enable     <= 1'b0;
          pixel_out1 <= '0;
          pixel_out2 <= '0;
          pixel_out3 <= '0;
          pixel_out4 <= '0;
          pixel_out5 <= '0;
          if (accept) begin
            if (wr_idx == IDX_W'(DEPTH - 1)) begin
              wr_idx <= '0;
              state  <= STREAM;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        STREAM: begin
          enable     <= 1'b1;
          pixel_out1 <= mem[rd_addr[0]];
          pixel_out2 <= mem[rd_addr[1]];
          pixel_out3 <= mem[rd_addr[2]];
          pixel_out4 <= mem[rd_addr[3]];
          pixel_out5 <= mem[rd_addr[4]];
          rd_base    <= rd_base + 1'b1;
          if (last_col) begin
            col <= '0;
            if (last_band) state <= DONE;
            else           band  <= band + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DONE: begin
          enable     <= 1'b0;
          done       <= 1'b1;
          pixel_out1 <= '0;
          pixel_out2 <= '0;
          pixel_out3 <= '0;
          pixel_out4 <= '0;
          pixel_out5 <= '0;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_gaussian_column_feeder.sv
// Scoreboarded bench: an 8x6 feeder (nominal, stalled, reset mid-stream) and a
// 16x5 feeder (single band); monitors pop expected columns while enable is high.
module tb_gaussian_column_feeder;

  localparam int RUN_A = (6 - 4) * 8;
  localparam int RUN_B = (5 - 4) * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a = 1'b1, valid_a = 1'b0, ready_a, en_a, done_a;
  logic [4:0] pix_a = '0, a1, a2, a3, a4, a5;
  logic       rst_b = 1'b1, valid_b = 1'b0, ready_b, en_b, done_b;
  logic [4:0] pix_b = '0, b1, b2, b3, b4, b5;
  logic [24:0] col_a, col_b;
  logic [24:0] exp_a[$];
  logic [24:0] exp_b[$];

  assign col_a = {a1, a2, a3, a4, a5};
  assign col_b = {b1, b2, b3, b4, b5};

  gaussian_column_feeder #(.BIT_LENGTH(5), .IMG_WIDTH(8), .IMG_HEIGHT(6)) dut_a (
    .clk(clk), .reset(rst_a), .in_valid(valid_a), .pixel_in(pix_a), .in_ready(ready_a),
    .pixel_out1(a1), .pixel_out2(a2), .pixel_out3(a3), .pixel_out4(a4), .pixel_out5(a5),
    .enable(en_a), .done(done_a));

  gaussian_column_feeder #(.BIT_LENGTH(5), .IMG_WIDTH(16), .IMG_HEIGHT(5)) dut_b (
    .clk(clk), .reset(rst_b), .in_valid(valid_b), .pixel_in(pix_b), .in_ready(ready_b),
    .pixel_out1(b1), .pixel_out2(b2), .pixel_out3(b3), .pixel_out4(b4), .pixel_out5(b5),
    .enable(en_b), .done(done_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Image for the 8-wide feeder: mode 0 is (row*8+col) mod 32, mode 1 is constant 7.
  function automatic logic [4:0] pv_a(input int mode, input int r, input int c);
    if (mode == 0) return 5'((r * 8 + c) % 32);
    return 5'd7;
  endfunction

  // ---------------- monitors ----------------
  int run_a = 0, run_b = 0;
  bit prev_a = 0, prev_b = 0;

  always @(negedge clk) begin
    if (rst_a) begin
      run_a = 0;
      prev_a = 0;
    end else begin
      if (en_a) begin
        run_a++;
        if (exp_a.size() == 0) check("col_a_unexpected", {7'd0, col_a}, 32'hffff_ffff);
        else check("col_a", {7'd0, col_a}, {7'd0, exp_a.pop_front()});
      end else begin
        check("idle_zero_a", {7'd0, col_a}, 32'd0);
        if (prev_a) begin
          check("run_len_a", run_a, RUN_A);
          check("done_at_fall_a", {31'd0, done_a}, 32'd1);
          run_a = 0;
        end
      end
      prev_a = en_a;
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      run_b = 0;
      prev_b = 0;
    end else begin
      if (en_b) begin
        run_b++;
        if (exp_b.size() == 0) check("col_b_unexpected", {7'd0, col_b}, 32'hffff_ffff);
        else check("col_b", {7'd0, col_b}, {7'd0, exp_b.pop_front()});
      end else begin
        check("idle_zero_b", {7'd0, col_b}, 32'd0);
        if (prev_b) begin
          check("run_len_b", run_b, RUN_B);
          check("done_at_fall_b", {31'd0, done_b}, 32'd1);
          run_b = 0;
        end
      end
      prev_b = en_b;
    end
  end

  // ---------------- drivers ----------------
  task automatic reset_a();
    @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    check("rst_ready_a", {31'd0, ready_a}, 32'd1);
    check("rst_enable_a", {31'd0, en_a}, 32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_pixels_a", {7'd0, col_a}, 32'd0);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1 check("post_rst_ready_a", {31'd0, ready_a}, 32'd1);
  endtask

  task automatic push_a(input int mode);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++)
        exp_a.push_back({pv_a(mode, r, c), pv_a(mode, r + 1, c), pv_a(mode, r + 2, c),
                         pv_a(mode, r + 3, c), pv_a(mode, r + 4, c)});
  endtask

  task automatic load_a(input int mode, input bit stall, input bit hold_after);
    int idx = 0;
    int cyc = 0;
    while (idx < 48 && cyc < 2000) begin
      @(negedge clk);
      valid_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_a   = pv_a(mode, idx / 8, idx % 8);
      @(posedge clk);
      if (valid_a) idx++;
      cyc++;
    end
    check("load_a_accepts", idx, 48);
    @(negedge clk);
    valid_a = hold_after;
    pix_a   = 5'd31;
    check("enable_low_after_last_accept", {31'd0, en_a}, 32'd0);
    check("ready_low_in_stream", {31'd0, ready_a}, 32'd0);
    @(negedge clk);
    check("enable_rise_latency", {31'd0, en_a}, 32'd1);
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_a_seen", {31'd0, done_a}, 32'd1);
    check("queue_a_drained", exp_a.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    // Nominal stream with pixel 31 held valid through STREAM and DONE.
    reset_a();
    push_a(0);
    load_a(0, 1'b0, 1'b1);
    wait_done_a();
    repeat (10) @(negedge clk);
    check("done_sticky_a", {31'd0, done_a}, 32'd1);
    check("enable_stays_low_a", {31'd0, en_a}, 32'd0);
    check("ready_low_in_done", {31'd0, ready_a}, 32'd0);
    valid_a = 1'b0;

    // Same image with random load stalls.
    reset_a();
    push_a(0);
    load_a(0, 1'b1, 1'b0);
    wait_done_a();

    // Reset part-way into the stream, then a constant-7 image.
    reset_a();
    push_a(0);
    load_a(0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset_a();
    exp_a.delete();
    push_a(1);
    load_a(1, 1'b0, 1'b0);
    wait_done_a();

    // Single-band 16x5 image of 31s.
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1 check("post_rst_ready_b", {31'd0, ready_b}, 32'd1);
    for (int i = 0; i < 16; i++) exp_b.push_back({5{5'd31}});
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      valid_b = 1'b1;
      pix_b   = 5'd31;
    end
    @(negedge clk);
    valid_b = 1'b0;
    check("enable_low_after_last_accept_b", {31'd0, en_b}, 32'd0);
    @(negedge clk);
    check("enable_rise_latency_b", {31'd0, en_b}, 32'd1);
    begin
      int n = 0;
      while (!done_b && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("done_b_seen", {31'd0, done_b}, 32'd1);
    check("queue_b_drained", exp_b.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
